// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared types and constants for the cache block fill initiator
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int ADDR_WIDTH_DEFAULT      = 16;
  localparam int WORDS_PER_BLOCK_DEFAULT = 8;
  localparam int OFFSET_BITS             = $clog2(WORDS_PER_BLOCK_DEFAULT);
  localparam int MEM_READ_LATENCY        = 4;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss, memory read and cache fill signals of the block fill initiator
interface cache_fill_fsm_if
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  fsm_busy;
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  mem_data_valid;
  logic [15:0]           mem_data_in;
  logic                  write_data_array;
  logic [ADDR_WIDTH-1:0] fill_address;
  logic [15:0]           fill_data;
  logic                  write_tag_array;

  modport master (
    input  miss_detected, miss_address, mem_data_valid, mem_data_in,
    output fsm_busy, mem_enable, memory_address,
    output write_data_array, fill_address, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, mem_data_valid, mem_data_in,
    input  fsm_busy, mem_enable, memory_address,
    input  write_data_array, fill_address, fill_data, write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_block_offset_counter.sv
// rtl/cache_fill_fsm_block_offset_counter.sv - counts the words of one block from a start offset
// The offset wraps inside the block; the count saturates at WORDS_PER_BLOCK and raises done.
module block_offset_counter #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] start_offset,
  input  logic                               enable,
  output logic                               done,
  output logic                               last,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] offset
);

  localparam int OFS_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFS_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_BLOCK);

  logic [CNT_W-1:0] count_q;
  logic [OFS_W-1:0] start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      start_q <= '0;
    end else if (load) begin
      count_q <= '0;
      start_q <= start_offset;
    end else if (enable && !done) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign done   = (count_q == FULL);
  assign last   = (count_q == FULL - CNT_W'(1));
  // Adding in OFS_W bits drops the carry, so the offset never leaves the block.
  assign offset = start_q + count_q[OFS_W-1:0];

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - fetches one cache block on a miss and streams it into the data/tag arrays
// Build macro CRITICAL_WORD_FIRST_EN starts issue and receive at the missed word instead of word 0.
module cache_fill_fsm
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  cache_fill_fsm_if.master bus
);

  localparam int OFS_W = $clog2(WORDS_PER_BLOCK);
  localparam int BLK_W = OFS_W + 1;

  fill_state_t               state_q;
  fill_state_t               state_d;
  logic [ADDR_WIDTH-1:BLK_W] base_q;
  logic [OFS_W-1:0]          start_offset;
  logic [OFS_W-1:0]          issue_offset;
  logic [OFS_W-1:0]          rx_offset;
  logic                      issue_done;
  logic                      issue_last_unused;
  logic                      rx_done;
  logic                      rx_last;
  logic                      load;
  logic                      issue_en;
  logic                      fill_write;
  logic [BLK_W-1:0]          miss_low_unused;

  assign load            = (state_q == IDLE);
  assign issue_en        = (state_q == FILL) && !issue_done;
  assign fill_write      = (state_q == FILL) && bus.mem_data_valid && !rx_done;
  assign miss_low_unused = bus.miss_address[BLK_W-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_offset = bus.miss_address[BLK_W-1:1];
`else
  assign start_offset = '0;
`endif

  block_offset_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .start_offset (start_offset),
    .enable       (issue_en),
    .done         (issue_done),
    .last         (issue_last_unused),
    .offset       (issue_offset)
  );

  block_offset_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_rx_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .start_offset (start_offset),
    .enable       (fill_write),
    .done         (rx_done),
    .last         (rx_last),
    .offset       (rx_offset)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if ((state_q == IDLE) && bus.miss_detected) begin
      base_q <= bus.miss_address[ADDR_WIDTH-1:BLK_W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.miss_detected) state_d = FILL;
      FILL:    if (fill_write && rx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Returns arriving while IDLE are stale (fill cut short by reset) and are dropped.
  always_comb begin
    bus.fsm_busy         = 1'b0;
    bus.mem_enable       = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.fill_address     = '0;
    bus.fill_data        = '0;
    bus.write_tag_array  = 1'b0;
    if (state_q == FILL) begin
      bus.fsm_busy = 1'b1;
      if (issue_en) begin
        bus.mem_enable     = 1'b1;
        bus.memory_address = {base_q, issue_offset, 1'b0};
      end
      if (fill_write) begin
        bus.write_data_array = 1'b1;
        bus.fill_address     = {base_q, rx_offset, 1'b0};
        bus.fill_data        = bus.mem_data_in;
        bus.write_tag_array  = rx_last;
      end
    end
  end

  a_return_follows_request: assert property (@(posedge clk) disable iff (!rst_n)
    fill_write |-> $past(bus.mem_enable, MEM_READ_LATENCY));

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - scoreboard bench for cache_fill_fsm with a fixed-latency memory model
module tb_cache_fill_fsm;
  import cache_fill_pkg::*;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } req_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst_n;
  logic inject;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   busy_run;
  req_t req_q[$];
  wr_t  wr_q[$];
  int   busy_q[$];

  cache_fill_fsm_if #(.ADDR_WIDTH(16)) bus ();

  cache_fill_fsm #(
    .ADDR_WIDTH      (16),
    .WORDS_PER_BLOCK (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Hand-computed block base and start offset; c is the cycle in which the miss is presented.
  task automatic push_fill(input logic [15:0] base, input int start, input int c,
                           input int n_req, input int n_wr, input int busy_len);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base | 16'(((start + i) % 8) * 2);
      if (i < n_req) req_q.push_back('{addr: a, cyc: c + 1 + i});
      if (i < n_wr)
        wr_q.push_back('{addr: a, data: mem_word(a), tag: (i == 7), cyc: c + 1 + MEM_READ_LATENCY + i});
    end
    busy_q.push_back(busy_len);
  endtask

  task automatic run_fill(input logic [15:0] miss, input logic [15:0] base, input int start);
    int c;
    @(negedge clk);
    bus.miss_address  = miss;
    bus.miss_detected = 1'b1;
    c = cyc;
    push_fill(base, start, c, 8, 8, 12);
    @(negedge clk);
    bus.miss_detected = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory: a request seen in cycle t returns its word in cycle t + MEM_READ_LATENCY.
  initial begin
    logic [MEM_READ_LATENCY-1:0] pv;
    logic [15:0]                 pa [MEM_READ_LATENCY];
    logic                        req;
    logic [15:0]                 ra;
    pv = '0;
    for (int i = 0; i < MEM_READ_LATENCY; i++) pa[i] = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = '0;
    forever begin
      @(negedge clk);
      req = bus.mem_enable;
      ra  = bus.memory_address;
      @(posedge clk);
      #1;
      for (int i = MEM_READ_LATENCY - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = req;
      pa[0] = ra;
      if (pv[MEM_READ_LATENCY-1]) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = mem_word(pa[MEM_READ_LATENCY-1]);
      end else if (inject) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = 16'hBEEF;
      end else begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request, a write or a busy edge.
  initial begin
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_enable) begin
        if (req_q.size() == 0) flag($sformatf("unexpected request addr 0x%0h", bus.memory_address));
        else begin
          req_t e;
          e = req_q.pop_front();
          check("req_addr", 32'(bus.memory_address), 32'(e.addr));
          check("req_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.write_tag_array && !bus.write_data_array) flag("tag write without data write");
      if (bus.write_data_array) begin
        if (wr_q.size() == 0) flag($sformatf("unexpected write addr 0x%0h", bus.fill_address));
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("fill_addr", 32'(bus.fill_address), 32'(w.addr));
          check("fill_data", 32'(bus.fill_data), 32'(w.data));
          check("tag_write", 32'(bus.write_tag_array), 32'(w.tag));
          check("fill_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
      if (bus.fsm_busy) busy_run++;
      else if (busy_run > 0) begin
        if (busy_q.size() == 0) flag("unexpected busy period");
        else check("busy_len", 32'(busy_run), 32'(busy_q.pop_front()));
        busy_run = 0;
      end
    end
  end

  initial begin
    int c;
    n_checks          = 0;
    n_fail            = 0;
    inject            = 1'b0;
    rst_n             = 1'b0;
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.fsm_busy), 0);
    check("rst_mem_enable", 32'(bus.mem_enable), 0);
    check("rst_mem_addr", 32'(bus.memory_address), 0);
    check("rst_write", 32'(bus.write_data_array), 0);
    check("rst_tag", 32'(bus.write_tag_array), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: plain fill
    run_fill(16'h1236, 16'h1230, CWF ? 3 : 0);

    // 2: top block must not wrap into 0x0000
    run_fill(16'hFFF2, 16'hFFF0, CWF ? 1 : 0);

    // 3: miss held across the end of a fill; second fill one IDLE cycle later
    @(negedge clk);
    bus.miss_address  = 16'h0A44;
    bus.miss_detected = 1'b1;
    c = cyc;
    push_fill(16'h0A40, CWF ? 2 : 0, c, 8, 8, 12);
    repeat (2) @(negedge clk);
    bus.miss_address = 16'h4E5A;
    push_fill(16'h4E50, CWF ? 5 : 0, c + 13, 8, 8, 12);
    repeat (12) @(negedge clk);
    bus.miss_detected = 1'b0;
    repeat (16) @(negedge clk);

    // 4: reset during the third return
    @(negedge clk);
    bus.miss_address  = 16'h3378;
    bus.miss_detected = 1'b1;
    c = cyc;
    push_fill(16'h3370, CWF ? 4 : 0, c, 6, 2, 6);
    @(negedge clk);
    bus.miss_detected = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.fsm_busy), 0);
    check("midrst_mem_enable", 32'(bus.mem_enable), 0);
    check("midrst_write", 32'(bus.write_data_array), 0);
    check("midrst_fill_data", 32'(bus.fill_data), 0);
    check("midrst_tag", 32'(bus.write_tag_array), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", 32'(bus.fsm_busy), 0);

    // 5: stray return while IDLE
    inject = 1'b1;
    @(negedge clk);
    check("idle_valid_write", 32'(bus.write_data_array), 0);
    check("idle_valid_data", 32'(bus.fill_data), 0);
    check("idle_valid_busy", 32'(bus.fsm_busy), 0);
    inject = 1'b0;
    @(negedge clk);
    check("idle_after_busy", 32'(bus.fsm_busy), 0);
    repeat (2) @(negedge clk);

`ifdef CRITICAL_WORD_FIRST_EN
    // 6: critical word first ordering 0x2A0A, 0x2A0C, 0x2A0E, 0x2A00 .. 0x2A08
    run_fill(16'h2A0A, 16'h2A00, 5);
`endif

    repeat (20) @(negedge clk);
    check("req_queue_left", 32'(req_q.size()), 0);
    check("wr_queue_left", 32'(wr_q.size()), 0);
    check("busy_queue_left", 32'(busy_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
